hazard_ctrl: RTL

Central pipeline controller for the 5-stage RV32 core. It observes the ID/EX/MEM stages and the instruction/data memory handshakes, then drives stall, flush and redirect controls for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also sequences multi-cycle EX operations (mul/div), discards wrong-path fetches returned after a redirect, and keeps stall/flush performance counters.

---
 rtl/hazard_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/redirect controller with multi-cycle sequencing,
// wrong-path fetch dropping and stall/flush performance counters.
module hazard_ctrl #(
  parameter int CNT_W  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  input  logic [31:0]       ex_branch_target,
  input  logic              ex_mc_start,
  input  logic              ex_mc_done,
  input  logic              mem_req,
  input  logic              dmem_ready,
  input  logic              imem_ready,
  output logic              pc_stall,
  output logic              pc_redirect,
  output logic [31:0]       redirect_pc,
  output logic              if_id_hazard,
  output logic              if_id_flush,
  output logic              id_ex_stall,
  output logic              id_ex_flush,
  output logic              ex_mem_stall,
  output logic              ex_mem_flush,
  output logic              mem_wb_flush,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);
  typedef enum logic {RUN, MC} state_t;
  state_t state_q, state_d;
  logic drop_q, drop_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic dmem_wait, load_use, mc_hold;
  assign dmem_wait = mem_req & ~dmem_ready;
  assign load_use  = ex_mem_read & (ex_rd != '0) &
                     ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
  assign mc_hold   = (state_q == RUN) ? ex_mc_start : ~ex_mc_done;
  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
  // Outputs are gated by rst so every control reads 0 while reset is asserted.
  always_comb begin
    pc_stall     = 1'b0;
    pc_redirect  = 1'b0;
    redirect_pc  = '0;
    if_id_hazard = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    ex_mem_flush = 1'b0;
    mem_wb_flush = 1'b0;
    state_d      = state_q;
    drop_d       = drop_q;
    if (rst) begin
      state_d = RUN;
    end else if (dmem_wait) begin
      pc_stall     = 1'b1;
      if_id_hazard = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (mc_hold) begin
      pc_stall     = 1'b1;
      if_id_hazard = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_flush = 1'b1;
      state_d      = MC;
    end else begin
      state_d = RUN;
      if (ex_branch_taken) begin
        pc_redirect = 1'b1;
        redirect_pc = ex_branch_target;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        drop_d      = ~imem_ready;
      end else if (load_use) begin
        pc_stall     = 1'b1;
        if_id_hazard = 1'b1;
        id_ex_flush  = 1'b1;
      end else if (!imem_ready) begin
        pc_stall    = 1'b1;
        if_id_flush = 1'b1;
      end else if (drop_q) begin
        if_id_flush = 1'b1;
        drop_d      = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      drop_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      stall_q <= stall_q + CNT_W'(pc_stall & ~pc_redirect);
      flush_q <= flush_q + CNT_W'(pc_redirect);
    end
  end
endmodule
